// File: rtl/scroll_pkg.sv
// Shared types and helpers for the scrolling-display sequencer.
package scroll_pkg;

    typedef enum logic [1:0] {
        DEF_DISP = 2'd0,
        PROG     = 2'd1,
        DISPLAY  = 2'd2
    } scroll_state_t;

    localparam int unsigned NIB_PER_WORD = 4;
    localparam int unsigned LED_W        = 16;

    // Thermometer code: bit i set for every i below n, saturating at LED_W ones.
    function automatic logic [LED_W-1:0] thermo16(input int unsigned n);
        logic [LED_W-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < LED_W; i++) begin
            t[i] = (i < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Mod-M free-running counter; o_max_tick marks the last count of each period.
module scroll_tick_gen #(
    parameter int unsigned M = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_max_tick
);

    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (r_count == CW'(M - 1)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_max_tick = (r_count == CW'(M - 1));

endmodule

// File: rtl/scroll_controller.sv
// Sequencer owning the message BRAM: records switch words while programming and
// paces nibble reads into the display shift register otherwise.
module scroll_controller
    import scroll_pkg::*;
#(
    parameter int unsigned DEPTH_W = 4,
    parameter int unsigned TICK_M  = 100_000_000,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prog,
    input  logic                 enter_tick,
    input  logic [15:0]          sw,
    output logic                 wr_en,
    output logic [DEPTH_W-1:0]   wr_addr,
    output logic [15:0]          wr_data,
    output logic                 rd_en,
    output logic [DEPTH_W+1:0]   rd_addr,
    input  logic [3:0]           rd_data,
    output logic                 shift_en,
    output logic [3:0]           shift_nibble,
    output logic [DEPTH_W:0]     msg_len,
    output logic [15:0]          led
);

    localparam int unsigned AW    = DEPTH_W + 2;
    localparam int unsigned LW    = DEPTH_W + 1;
    localparam int unsigned LIM_W = DEPTH_W + 3;
    localparam int unsigned CAP   = 2 ** DEPTH_W;

    if ((TICK_M <= RD_LAT + 1) || (RD_LAT < 1)) begin : g_param_chk
        $error("scroll_controller: need RD_LAT >= 1 and TICK_M > RD_LAT+1");
    end

    scroll_state_t        r_state;
    logic                 r_entry;
    logic [DEPTH_W-1:0]   r_wr_ptr;
    logic [LW-1:0]        r_msg_len;
    logic                 r_wr_en;
    logic [DEPTH_W-1:0]   r_wr_addr;
    logic [15:0]          r_wr_data;
    logic [AW-1:0]        r_rd_ptr;
    logic [RD_LAT-1:0]    r_rd_vld;
    logic                 r_shift_en;
    logic [3:0]           r_shift_nibble;

    logic                 w_leave;
    logic                 w_wr_ok;
    logic [LW-1:0]        w_msg_len_nxt;
    logic [LIM_W-1:0]     w_lim;
    logic [AW-1:0]        w_rd_last;
    logic                 w_tick;
    logic                 w_rd_en;

    // Any state change this cycle; used to restart pacing and flush reads.
    always_comb begin
        w_leave       = (r_state == PROG) ? !prog : prog;
        w_wr_ok       = (r_state == PROG) && enter_tick && (r_msg_len < LW'(CAP));
        w_msg_len_nxt = w_wr_ok ? (r_msg_len + LW'(1)) : r_msg_len;
        w_lim         = (r_state == DEF_DISP) ? LIM_W'(CAP * NIB_PER_WORD)
                                              : {r_msg_len, 2'b00};
        w_rd_last     = AW'(w_lim - LIM_W'(1));
    end

    // Counter held clear through the entry cycle so the first tick lands TICK_M after entry.
    scroll_tick_gen #(
        .M (TICK_M)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (r_entry || w_leave || (r_state == PROG)),
        .o_max_tick (w_tick)
    );

    assign w_rd_en = w_tick && (r_state != PROG);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= DEF_DISP;
            r_entry        <= 1'b1;
            r_wr_ptr       <= '0;
            r_msg_len      <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_rd_ptr       <= '0;
            r_rd_vld       <= '0;
            r_shift_en     <= 1'b0;
            r_shift_nibble <= '0;
        end else begin
            r_wr_en    <= 1'b0;
            r_shift_en <= 1'b0;
            r_entry    <= w_leave;

            case (r_state)
                DEF_DISP, DISPLAY: begin
                    if (prog) begin
                        r_state   <= PROG;
                        r_wr_ptr  <= '0;
                        r_msg_len <= '0;
                    end
                end
                PROG: begin
                    // A write coinciding with prog falling still lands before exit.
                    if (w_wr_ok) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_wr_ptr;
                        r_wr_data <= sw;
                        r_wr_ptr  <= r_wr_ptr + DEPTH_W'(1);
                        r_msg_len <= w_msg_len_nxt;
                    end
                    if (!prog) begin
                        r_state <= (w_msg_len_nxt != '0) ? DISPLAY : DEF_DISP;
                    end
                end
                default: r_state <= DEF_DISP;
            endcase

            if (w_leave) begin
                r_rd_ptr <= '0;
                r_rd_vld <= '0;
            end else begin
                if (w_rd_en) begin
                    r_rd_ptr <= (r_rd_ptr == w_rd_last) ? '0 : (r_rd_ptr + AW'(1));
                end
                r_rd_vld[0] <= w_rd_en;
                for (int unsigned i = 1; i < RD_LAT; i++) begin
                    r_rd_vld[i] <= r_rd_vld[i-1];
                end
                if (r_rd_vld[RD_LAT-1]) begin
                    r_shift_en     <= 1'b1;
                    r_shift_nibble <= rd_data;
                end
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign rd_en        = w_rd_en;
    assign rd_addr      = r_rd_ptr;
    assign shift_en     = r_shift_en;
    assign shift_nibble = r_shift_nibble;
    assign msg_len      = r_msg_len;
    assign led          = (r_state == PROG) ? thermo16(32'(r_msg_len)) : '0;

endmodule

// File: tb/tb_scroll_controller.sv
// Directed bench for scroll_controller with a one-cycle-latency nibble BRAM model.
module tb_scroll_controller;

    localparam int unsigned DEPTH_W = 2;
    localparam int unsigned TICK_M  = 8;
    localparam int unsigned RD_LAT  = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 prog;
    logic                 enter_tick;
    logic [15:0]          sw;
    logic                 wr_en;
    logic [DEPTH_W-1:0]   wr_addr;
    logic [15:0]          wr_data;
    logic                 rd_en;
    logic [DEPTH_W+1:0]   rd_addr;
    logic [3:0]           rd_data;
    logic                 shift_en;
    logic [3:0]           shift_nibble;
    logic [DEPTH_W:0]     msg_len;
    logic [15:0]          led;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [4];
    logic [3:0]  seq [16];

    scroll_controller #(
        .DEPTH_W (DEPTH_W),
        .TICK_M  (TICK_M),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .prog         (prog),
        .enter_tick   (enter_tick),
        .sw           (sw),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .shift_en     (shift_en),
        .shift_nibble (shift_nibble),
        .msg_len      (msg_len),
        .led          (led)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: word writes on port A, nibble reads (0 = bits 15:12) on port B.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= 4'(mem[rd_addr[3:2]] >> (4 * (3 - int'(rd_addr[1:0]))));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller sits at the negedge of the state-entry cycle (cycle 0).
    task automatic run_scroll(input int ncyc, input int lim);
        int nrd = 0;
        int nsh = 0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            chk("rd_en_pace", rd_en, (cyc % TICK_M) == 0);
            chk("shift_en_pace", shift_en, (cyc >= 10) && ((cyc % TICK_M) == 2));
            if (rd_en) begin
                chk("rd_addr", rd_addr, nrd % lim);
                nrd++;
            end
            if (shift_en) begin
                chk("shift_nibble", shift_nibble, seq[nsh % lim]);
                nsh++;
            end else if (nsh > 0) begin
                chk("shift_nibble_hold", shift_nibble, seq[(nsh - 1) % lim]);
            end
        end
        chk("rd_count", nrd, ncyc / TICK_M);
        chk("shift_count", nsh, (ncyc - 2) / TICK_M);
    endtask

    task automatic do_enter(input logic [15:0] d, input bit exp_wr, input int exp_addr,
                            input int exp_len, input logic [15:0] exp_led);
        enter_tick = 1'b1;
        sw         = d;
        @(negedge clk);
        enter_tick = 1'b0;
        chk("wr_en", wr_en, exp_wr);
        if (exp_wr) begin
            chk("wr_addr", wr_addr, exp_addr);
            chk("wr_data", wr_data, d);
        end
        chk("msg_len", msg_len, exp_len);
        chk("led", led, exp_led);
        @(negedge clk);
        chk("wr_en_one_cycle", wr_en, 1'b0);
    endtask

    initial begin
        bit got;
        mem[0] = 16'h0123;
        mem[1] = 16'h4567;
        mem[2] = 16'h89AB;
        mem[3] = 16'hCDEF;
        reset = 1'b1; prog = 1'b0; enter_tick = 1'b0; sw = '0;
        repeat (3) @(negedge clk);

        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_shift_nibble", shift_nibble, 0);
        chk("rst_msg_len", msg_len, 0);
        chk("rst_led", led, 0);
        reset = 1'b0;

        // Default display over the whole initial BRAM: nibbles 0..F, L = 16.
        for (int k = 0; k < 16; k++) seq[k] = 4'(k);
        run_scroll(140, 16);

        // Program three words.
        prog = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk("prog_rd_en", rd_en, 0);
            chk("prog_shift_en", shift_en, 0);
            @(negedge clk);
        end
        chk("prog_msg_len0", msg_len, 0);
        chk("prog_led0", led, 16'h0000);
        do_enter(16'h1234, 1'b1, 0, 1, 16'h0001);
        do_enter(16'hABCD, 1'b1, 1, 2, 16'h0003);
        do_enter(16'h0F0F, 1'b1, 2, 3, 16'h0007);

        // Display the 3-word message, L = 12.
        seq[0] = 4'h1; seq[1] = 4'h2; seq[2]  = 4'h3; seq[3]  = 4'h4;
        seq[4] = 4'hA; seq[5] = 4'hB; seq[6]  = 4'hC; seq[7]  = 4'hD;
        seq[8] = 4'h0; seq[9] = 4'hF; seq[10] = 4'h0; seq[11] = 4'hF;
        prog = 1'b0;
        @(negedge clk);
        chk("disp_led", led, 0);
        chk("disp_msg_len", msg_len, 3);
        run_scroll(110, 12);

        // prog rises the cycle after a read: that read must never strobe.
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rd_en) got = 1'b1;
        end
        chk("wait_rd_en", got, 1'b1);
        @(negedge clk);
        prog = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("flush_shift_en", shift_en, 0);
            chk("flush_rd_en", rd_en, 0);
        end
        chk("reprog_msg_len", msg_len, 0);

        // Five enters: the fifth is dropped at full capacity.
        do_enter(16'hFEDC, 1'b1, 0, 1, 16'h0001);
        do_enter(16'hBA98, 1'b1, 1, 2, 16'h0003);
        do_enter(16'h7654, 1'b1, 2, 3, 16'h0007);
        do_enter(16'h3210, 1'b1, 3, 4, 16'h000F);
        do_enter(16'hEEEE, 1'b0, 0, 4, 16'h000F);

        // DISPLAY, back to PROG with no enters, then out to DEF_DISP with L = 16.
        prog = 1'b0;
        @(negedge clk);
        prog = 1'b1;
        @(negedge clk);
        chk("empty_msg_len", msg_len, 0);
        chk("empty_led", led, 0);
        prog = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) seq[k] = 4'(15 - k);
        run_scroll(140, 16);

        // Reset coinciding with enter_tick: no write lands.
        prog = 1'b1;
        @(negedge clk);
        enter_tick = 1'b1;
        sw         = 16'h5A5A;
        reset      = 1'b1;
        @(negedge clk);
        chk("rstw_wr_en", wr_en, 0);
        chk("rstw_msg_len", msg_len, 0);
        chk("rstw_led", led, 0);
        chk("rstw_shift_nibble", shift_nibble, 0);
        reset      = 1'b0;
        enter_tick = 1'b0;
        prog       = 1'b0;
        @(negedge clk);
        chk("rstw_wr_en_after", wr_en, 0);
        chk("rstw_msg_len_after", msg_len, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scroll_controller.md
# scroll_controller

Sequencer for the scrolling-display datapath. Owns the message BRAM's write port during programming and its nibble-wide read port during display. Paces reads with an internal scroll tick and delivers each fetched nibble to the display shift register as a one-cycle strobe. Sits between the debounced enter button, switches and prog input on one side and the BRAM, shift register and LEDs on the other.

## Interface
- DEPTH_W, 4, BRAM word-address width; message capacity is 2^DEPTH_W 16-bit words.
- TICK_M, 100_000_000, scroll period in clk cycles; must be > RD_LAT+1 (elaboration-time check).
- RD_LAT, 1, BRAM read latency in cycles (≥1).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- prog  in  1  level; high requests programming mode.
- enter_tick  in  1  one-cycle pulse from the debouncer.
- sw  in  16  word to be written.
- wr_en  out  1  BRAM port-A write strobe.
- wr_addr  out  DEPTH_W  BRAM word address.
- wr_data  out  16  BRAM write data.
- rd_en  out  1  BRAM port-B read enable.
- rd_addr  out  DEPTH_W+2  nibble address; [DEPTH_W+1:2] selects the word, [1:0] selects the nibble, 0 = sw[15:12].
- rd_data  in  4  BRAM nibble, valid RD_LAT cycles after rd_en.
- shift_en  out  1  one-cycle strobe; shift shift_nibble into the display register.
- shift_nibble  out  4  nibble accompanying shift_en.
- msg_len  out  DEPTH_W+1  number of words programmed.
- led  out  16  status LEDs.

## Operation
- States: DEF_DISP, PROG, DISPLAY. Reset state is DEF_DISP.
- DEF_DISP → PROG when prog = 1.
- PROG → DISPLAY when prog = 0 and msg_len ≠ 0.
- PROG → DEF_DISP when prog = 0 and msg_len = 0.
- DISPLAY → PROG when prog = 1.
- Entering PROG clears the write pointer and msg_len to 0.
- In PROG, each enter_tick with msg_len < 2^DEPTH_W produces wr_en = 1 for exactly that cycle, with wr_addr = pointer and wr_data = sw. The pointer and msg_len then increment.
- When msg_len = 2^DEPTH_W (full), enter_tick is ignored: no wr_en, no count change.
- enter_tick is ignored outside PROG.
- enter_tick in the same cycle prog falls: the write is accepted, then PROG exits.
- Scroll limit L: in DEF_DISP, L = 4·2^DEPTH_W (entire BRAM, initial contents); in DISPLAY, L = 4·msg_len.
- In DEF_DISP/DISPLAY, each scroll tick issues rd_en with rd_addr = read pointer. The pointer then increments, wrapping from L−1 to 0.
- Entering any state clears the read pointer and the tick counter and flushes in-flight reads. No shift_en is produced for reads issued in the previous state.
- In PROG, rd_en and shift_en stay 0.
- led: in PROG, thermometer of msg_len (bit i = 1 for i < msg_len, saturating at 16). Otherwise 0.

## Timing
- Reset values: state DEF_DISP; every output 0; tick counter, read pointer, write pointer, msg_len and read-valid pipeline all 0.
- Tick counter counts 0..TICK_M−1 in display states. Scroll tick occurs in the cycle where count = TICK_M−1; the first tick after state entry occurs TICK_M cycles after entry.
- Tick in cycle T: rd_en = 1 in cycle T (decoded from registered state).
- rd_data is sampled in cycle T+RD_LAT.
- shift_en = 1 and shift_nibble = that data in cycle T+RD_LAT+1 (both registered).
- shift_nibble holds its value between strobes.
- wr_en, wr_addr and wr_data are registered: they are asserted in the cycle after enter_tick is sampled, for one cycle.
- msg_len updates in the same cycle wr_en is asserted.
- Reset asserted mid-write or mid-read: the next cycle shows reset values; pending strobes are dropped.

## Structure
- Package scroll_pkg: scroll_state_t enum {DEF_DISP, PROG, DISPLAY}; constant NIB_PER_WORD = 4.
- Sub-module scroll_tick_gen: mod-TICK_M counter with synchronous clear and max_tick output.
- The FSM, write pointer, read pointer and the RD_LAT-deep valid shift pipeline live in scroll_controller.

## Test plan
Bench parameters: DEPTH_W = 2, TICK_M = 8, RD_LAT = 1, with a behavioural BRAM model.
- Reset, prog = 0 → all outputs 0. First rd_en at cycle 8 with rd_addr = 0; shift_en at cycle 10; rd_addr cycles 0..15 then back to 0.
- prog = 1, then three enter_ticks with sw = 16'h1234, 16'hABCD, 16'h0F0F → three wr_en pulses at addresses 0, 1, 2; msg_len = 3; led = 16'h0007.
- Five enter_ticks in PROG → only four writes; msg_len saturates at 4; led = 16'h000F.
- After the 3-word program, prog = 0 → DISPLAY. shift_nibble sequence is 1, 2, 3, 4, A, B, C, D, 0, F, 0, F, then repeats from 1; rd_addr wraps 11 → 0.
- prog rises in the cycle after rd_en in DISPLAY → no shift_en follows; rd_en stays 0 while in PROG.
- prog = 1 and 0 with no enters → returns to DEF_DISP, L = 16. Reset asserted in the same cycle as enter_tick → no wr_en; msg_len = 0.
